instr_decoder_pipe: RTL

Parametrised, handshaked successor to the APCPU instruction decoder. Classifies each instruction word into an operand format and extracts ALU code, literal data and X/Y/Z register selects, plus per-field enables and an illegal-opcode flag. Sits between instruction fetch and the register file/ALU. Holds decoded results in a 2-entry output buffer with valid/ready handshaking on both sides, so fetch and execute can stall independently.

---
 rtl/apcpu_dec_pkg.sv | 64 ++++++
 rtl/dec_fifo2.sv | 61 ++++++
 rtl/instr_decoder_pipe.sv | 137 +++++++++++++
 3 files changed

// File: rtl/apcpu_dec_pkg.sv
// Shared types for the APCPU instruction decoder: format classes, opcode
// constants, the width-independent control record and the opcode classifier.
package apcpu_dec_pkg;

    typedef enum logic [3:0] {
        FMT_PASS = 4'd0,
        FMT_LIT  = 4'd1,
        FMT_XYZ  = 4'd2,
        FMT_XSL  = 4'd3,
        FMT_XYX  = 4'd4,
        FMT_X    = 4'd5,
        FMT_Z    = 4'd6,
        FMT_ZY   = 4'd7,
        FMT_ILL  = 4'd8
    } fmt_e;

    localparam logic [7:0] OP_PASS    = 8'd255;
    localparam logic [7:0] OP_LAST_ISA = 8'd49;

    typedef struct packed {
        fmt_e fmt;
        logic en_x;
        logic en_y;
        logic en_z;
        logic illegal;
    } dec_rec_t;

    function automatic fmt_e decode_fmt(input logic [7:0] opcode);
        fmt_e f;
        case (opcode)
            OP_PASS:                                         f = FMT_PASS;
            8'd1, 8'd2, 8'd5, 8'd6, 8'd9, 8'd11, 8'd23, 8'd24,
            8'd26, 8'd27, 8'd28, 8'd29, 8'd30, 8'd33, 8'd37,
            8'd40, 8'd41:                                    f = FMT_LIT;
            8'd3, 8'd4, 8'd7, 8'd8, 8'd10, 8'd12, 8'd31, 8'd32,
            8'd39, 8'd42, 8'd44, 8'd45, 8'd48:               f = FMT_XYZ;
            8'd13, 8'd14, 8'd15, 8'd16:                      f = FMT_XSL;
            8'd17, 8'd18, 8'd19, 8'd20, 8'd21, 8'd22, 8'd38: f = FMT_XYX;
            8'd25, 8'd34:                                    f = FMT_X;
            8'd35, 8'd46:                                    f = FMT_Z;
            8'd36, 8'd49:                                    f = FMT_ZY;
            default:                                         f = FMT_ILL;
        endcase
        return f;
    endfunction

    // Enables and the illegal flag follow purely from the format class.
    function automatic dec_rec_t fmt_ctrl(input fmt_e f);
        dec_rec_t r;
        r = '0;
        r.fmt = f;
        case (f)
            FMT_LIT:          begin r.en_x = 1'b1; r.en_z = 1'b1; end
            FMT_XYZ, FMT_XYX: begin r.en_x = 1'b1; r.en_y = 1'b1; r.en_z = 1'b1; end
            FMT_XSL, FMT_X:   r.en_x = 1'b1;
            FMT_Z:            r.en_z = 1'b1;
            FMT_ZY:           begin r.en_y = 1'b1; r.en_z = 1'b1; end
            FMT_ILL:          r.illegal = 1'b1;
            default:          r.illegal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dec_fifo2.sv
// Generic 2-entry valid/ready FIFO with synchronous flush; in_ready depends
// only on the registered occupancy so there is no ready-to-ready path.
module dec_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [1:0]       r_count;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic             w_push;
    logic             w_pop;

    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_head;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // r_head is always the oldest entry; r_tail only matters at count 2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else if (flush) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= in_data;
                    else                 r_tail <= in_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= in_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= in_data;
                    end
                end
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instr_decoder_pipe.sv
// APCPU instruction decoder: combinational field extraction on the input word,
// buffered through a 2-entry handshaked FIFO, plus a saturating illegal counter.
module instr_decoder_pipe
    import apcpu_dec_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int OP_W    = 8,
    parameter int REG_W   = 3,
    parameter int CNT_W   = 8,
    localparam int DATA_W = INSTR_W - OP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [REG_W-1:0]   ap_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OP_W-1:0]    alu_code,
    output logic [DATA_W-1:0]  dec_data,
    output logic [REG_W-1:0]   reg_sel_x,
    output logic [REG_W-1:0]   reg_sel_y,
    output logic [REG_W-1:0]   reg_sel_z,
    output logic               reg_en_x,
    output logic               reg_en_y,
    output logic               reg_en_z,
    output logic [3:0]         fmt,
    output logic               illegal,
    output logic [CNT_W-1:0]   ill_cnt
);

    typedef struct packed {
        logic [OP_W-1:0]   alu;
        logic [DATA_W-1:0] data;
        logic [REG_W-1:0]  x;
        logic [REG_W-1:0]  y;
        logic [REG_W-1:0]  z;
        dec_rec_t          ctrl;
    } payload_t;

    localparam int PAY_W = $bits(payload_t);

    logic [OP_W-1:0]    w_op;
    logic [OP_W-1:0]    w_opHi;
    logic [REG_W-1:0]   w_xf;
    logic [REG_W-1:0]   w_yf;
    logic [REG_W-1:0]   w_zf;
    logic [2*REG_W-1:0] w_sl;
    fmt_e               w_fmt;
    payload_t           w_rec;
    payload_t           w_head;
    payload_t           w_outRec;
    logic               w_accept;
    logic [CNT_W-1:0]   r_illCnt;

    assign w_op   = in_instr[OP_W-1:0];
    assign w_opHi = w_op >> 8;
    assign w_xf   = in_instr[OP_W +: REG_W];
    assign w_yf   = in_instr[OP_W+REG_W +: REG_W];
    assign w_zf   = in_instr[OP_W+2*REG_W +: REG_W];
    assign w_sl   = in_instr[OP_W+REG_W +: 2*REG_W];
    // Opcodes wider than 8 bits are only legal when the upper bits are zero.
    assign w_fmt  = (w_opHi != '0) ? FMT_ILL : decode_fmt(w_op[7:0]);

    always_comb begin
        w_rec      = '0;
        w_rec.alu  = w_op;
        w_rec.ctrl = fmt_ctrl(w_fmt);
        case (w_fmt)
            FMT_LIT: begin
                w_rec.x    = ap_sel;
                w_rec.z    = ap_sel;
                w_rec.data = in_instr[INSTR_W-1:OP_W];
            end
            FMT_XYZ: begin
                w_rec.x = w_xf;
                w_rec.y = w_yf;
                w_rec.z = w_zf;
            end
            FMT_XSL: begin
                w_rec.x    = w_xf;
                w_rec.data = DATA_W'(w_sl);
            end
            FMT_XYX: begin
                w_rec.x = w_xf;
                w_rec.y = w_yf;
                w_rec.z = w_xf;
            end
            FMT_X:   w_rec.x = w_xf;
            FMT_Z:   w_rec.z = w_xf;
            FMT_ZY: begin
                w_rec.z = w_xf;
                w_rec.y = w_yf;
            end
            default: w_rec.x = '0;
        endcase
    end

    dec_fifo2 #(.WIDTH(PAY_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_rec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_head)
    );

    assign w_accept = in_valid && in_ready && !flush;

    // Dropped-by-flush words never reach the buffer, so they are not counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_illCnt <= '0;
        end else if (w_accept && w_rec.ctrl.illegal && (r_illCnt != '1)) begin
            r_illCnt <= r_illCnt + 1'b1;
        end
    end

    assign w_outRec  = out_valid ? w_head : '0;
    assign alu_code  = w_outRec.alu;
    assign dec_data  = w_outRec.data;
    assign reg_sel_x = w_outRec.x;
    assign reg_sel_y = w_outRec.y;
    assign reg_sel_z = w_outRec.z;
    assign reg_en_x  = w_outRec.ctrl.en_x;
    assign reg_en_y  = w_outRec.ctrl.en_y;
    assign reg_en_z  = w_outRec.ctrl.en_z;
    assign fmt       = w_outRec.ctrl.fmt;
    assign illegal   = w_outRec.ctrl.illegal;
    assign ill_cnt   = r_illCnt;

endmodule
